// File: rtl/sqr_ctrl_pkg.sv
// Shared types and datapath constants for the iterative modular-squaring sequencer.
package sqr_ctrl_pkg;

  localparam int NUM_DIGITS = 130;
  localparam int DIGIT_W    = 16;
  localparam int ACC_W      = 19;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE,
    ST_CKPT
  } ctrl_state_e;

endpackage

// File: rtl/sqr_phase_gen.sv
// Phase counter for one squaring iteration: one-hot stage enables, accumulate strobe, wrap pulse.
module sqr_phase_gen
  import sqr_ctrl_pkg::*;
#(
  parameter int PIPE_LAT = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run_en_i,
  input  logic                clr_i,
  output logic [PIPE_LAT-1:0] stage_en_o,
  output logic                accum_en_o,
  output logic                wrap_o
);

  localparam int PH_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  logic [PH_W-1:0] phase_q, phase_d;
  logic            last_phase;

  assign last_phase = (phase_q == PH_W'(PIPE_LAT - 1));

  always_comb begin
    phase_d = phase_q;
    if (clr_i) begin
      phase_d = '0;
    end else if (run_en_i) begin
      phase_d = last_phase ? '0 : phase_q + PH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_q <= '0;
    else        phase_q <= phase_d;
  end

  assign stage_en_o = run_en_i ? ({{(PIPE_LAT-1){1'b0}}, 1'b1} << phase_q) : '0;
  assign accum_en_o = run_en_i & last_phase;
  assign wrap_o     = run_en_i & last_phase;

endmodule

// File: rtl/sqr_iter_ctrl.sv
// Sequencer for the iterative squaring datapath: job handshake, T iterations of PIPE_LAT steps, result handshake.
// Optional checkpoint pause every 2^CKPT_SHIFT iterations when ITER_CHECKPOINT_EN is defined.
module sqr_iter_ctrl
  import sqr_ctrl_pkg::*;
#(
  parameter int PIPE_LAT   = 3,
  parameter int ITER_W     = 64,
  parameter int CKPT_SHIFT = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [ITER_W-1:0]   t_in,
  input  logic                abort,
  output logic                load_en,
  output logic                sq_in_sel,
  output logic [PIPE_LAT-1:0] stage_en,
  output logic                accum_en,
  output logic                busy,
  output logic [ITER_W-1:0]   iter_cnt,
  output logic                result_valid,
  input  logic                result_ready,
  output logic                ckpt_valid,
  input  logic                ckpt_ack
);

  ctrl_state_e       state_q, state_d;
  logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d;
  logic [ITER_W-1:0] t_reg_q, t_reg_d;
  logic [ITER_W-1:0] iter_inc;
  logic              run_en, wrap;

  assign run_en   = (state_q == ST_RUN);
  assign iter_inc = iter_cnt_q + ITER_W'(1);

  sqr_phase_gen #(
    .PIPE_LAT (PIPE_LAT)
  ) u_phase (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_en_i   (run_en),
    .clr_i      (!run_en),
    .stage_en_o (stage_en),
    .accum_en_o (accum_en),
    .wrap_o     (wrap)
  );

  always_comb begin
    state_d    = state_q;
    iter_cnt_d = iter_cnt_q;
    t_reg_d    = t_reg_q;
    load_en    = 1'b0;
    sq_in_sel  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          t_reg_d    = t_in;
          iter_cnt_d = '0;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_en = 1'b1;
        state_d = (t_reg_q == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        sq_in_sel = 1'b1;
        if (wrap) begin
          iter_cnt_d = iter_inc;
          if (iter_inc == t_reg_q) begin
            state_d = ST_DONE;
          end
`ifdef ITER_CHECKPOINT_EN
          else if (iter_inc[CKPT_SHIFT-1:0] == '0) begin
            state_d = ST_CKPT;
          end
`endif
        end
      end
      ST_DONE: begin
        if (result_ready) state_d = ST_IDLE;
      end
`ifdef ITER_CHECKPOINT_EN
      ST_CKPT: begin
        if (ckpt_ack) state_d = ST_RUN;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    // Cancel outranks every other transition, including a start offered in the same cycle.
    if (abort) begin
      state_d    = ST_IDLE;
      iter_cnt_d = iter_cnt_q;
      t_reg_d    = t_reg_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      iter_cnt_q <= '0;
      t_reg_q    <= '0;
    end else begin
      state_q    <= state_d;
      iter_cnt_q <= iter_cnt_d;
      t_reg_q    <= t_reg_d;
    end
  end

  assign start_ready  = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign result_valid = (state_q == ST_DONE);
  assign iter_cnt     = iter_cnt_q;

`ifdef ITER_CHECKPOINT_EN
  assign ckpt_valid = (state_q == ST_CKPT);
`else
  logic unused_ckpt;
  assign unused_ckpt = ckpt_ack ^ (CKPT_SHIFT == 0);
  assign ckpt_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_sqr_iter_ctrl.sv
// Directed bench for sqr_iter_ctrl (PIPE_LAT=3); checkpoint scenario runs when ITER_CHECKPOINT_EN is defined.
module tb_sqr_iter_ctrl;

  localparam int PIPE_LAT = 3;
  localparam int ITER_W   = 64;
`ifdef ITER_CHECKPOINT_EN
  localparam int CK_SH = 2;
`else
  localparam int CK_SH = 20;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start_valid = 1'b0;
  logic                start_ready;
  logic [ITER_W-1:0]   t_in = '0;
  logic                abort = 1'b0;
  logic                load_en;
  logic                sq_in_sel;
  logic [PIPE_LAT-1:0] stage_en;
  logic                accum_en;
  logic                busy;
  logic [ITER_W-1:0]   iter_cnt;
  logic                result_valid;
  logic                result_ready = 1'b0;
  logic                ckpt_valid;
  logic                ckpt_ack = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc, rv_cyc, load_cyc, stage_seen, onehot_bad, sr_bad, bad_rv;
  int acc_q[$];

  sqr_iter_ctrl #(
    .PIPE_LAT   (PIPE_LAT),
    .ITER_W     (ITER_W),
    .CKPT_SHIFT (CK_SH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .t_in         (t_in),
    .abort        (abort),
    .load_en      (load_en),
    .sq_in_sel    (sq_in_sel),
    .stage_en     (stage_en),
    .accum_en     (accum_en),
    .busy         (busy),
    .iter_cnt     (iter_cnt),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .ckpt_valid   (ckpt_valid),
    .ckpt_ack     (ckpt_ack)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Start at the current cycle (cycle 0), run to result_valid, hold off the ack for 'hold' cycles.
  task automatic run_job(input logic [63:0] t, input int hold);
    start_valid = 1'b1;
    t_in        = t;
    cyc         = 0;
    acc_q.delete();
    load_cyc = -1; stage_seen = 0; onehot_bad = 0; sr_bad = 0;
    step();
    start_valid = 1'b0;
    while (!result_valid && cyc < 400) begin
      if (load_en) load_cyc = cyc;
      if (accum_en) acc_q.push_back(cyc);
      if (stage_en != '0) stage_seen++;
      if (busy && !load_en && !ckpt_valid && $countones(stage_en) != 1) onehot_bad++;
      if (start_ready) sr_bad++;
      step();
    end
    rv_cyc = result_valid ? cyc : -1;
    for (int i = 0; i < hold; i++) begin
      check_eq("bp_valid", 64'(result_valid), 64'd1);
      check_eq("bp_iter", iter_cnt, t);
      check_eq("bp_start_ready", 64'(start_ready), 64'd0);
      step();
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check_eq("idle_after_ack", 64'(start_ready), 64'd1);
    check_eq("rv_clear", 64'(result_valid), 64'd0);
  endtask

  initial begin
    #1;
    check_eq("rst_start_ready", 64'(start_ready), 64'd1);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_outs", {59'd0, load_en, sq_in_sel, accum_en, result_valid, ckpt_valid}, 64'd0);
    check_eq("rst_stage_en", 64'(stage_en), 64'd0);
    check_eq("rst_iter", iter_cnt, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // T=0: straight from LOAD to DONE
    run_job(64'd0, 0);
    check_eq("t0_load_cyc", 64'(load_cyc), 64'd1);
    check_eq("t0_rv_cyc", 64'(rv_cyc), 64'd2);
    check_eq("t0_stage_seen", 64'(stage_seen), 64'd0);
    check_eq("t0_iter", iter_cnt, 64'd0);

    // T=4: four iterations of three cycles
    run_job(64'd4, 0);
    check_eq("t4_rv_cyc", 64'(rv_cyc), 64'd14);
    check_eq("t4_acc_n", 64'(acc_q.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      int a;
      a = (k < acc_q.size()) ? acc_q[k] : -1;
      check_eq($sformatf("t4_acc%0d", k), 64'(a), 64'(4 + 3 * k));
    end
    check_eq("t4_onehot_bad", 64'(onehot_bad), 64'd0);
    check_eq("t4_sr_busy", 64'(sr_bad), 64'd0);
    check_eq("t4_iter", iter_cnt, 64'd4);

    // T=2 with back-pressure on the result
    run_job(64'd2, 5);
    check_eq("t2_rv_cyc", 64'(rv_cyc), 64'd8);
    check_eq("t2_iter", iter_cnt, 64'd2);

    // Abort at cycle 8 of a T=10 job, new job at cycle 10
    start_valid = 1'b1; t_in = 64'd10; cyc = 0;
    step();
    start_valid = 1'b0;
    repeat (7) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("ab_busy", 64'(busy), 64'd0);
    check_eq("ab_enables", {60'd0, load_en, accum_en, sq_in_sel, result_valid}, 64'd0);
    check_eq("ab_stage_en", 64'(stage_en), 64'd0);
    check_eq("ab_iter", iter_cnt, 64'd2);
    step();
    run_job(64'd3, 0);
    check_eq("ab_new_rv_cyc", 64'(rv_cyc), 64'd11);
    check_eq("ab_new_iter", iter_cnt, 64'd3);

    // Abort concurrent with start in IDLE: no job accepted
    start_valid = 1'b1; abort = 1'b1; t_in = 64'd5;
    step();
    start_valid = 1'b0; abort = 1'b0;
    check_eq("ab_idle_busy", 64'(busy), 64'd0);
    check_eq("ab_idle_iter", iter_cnt, 64'd3);

    // Maximum T: still running after a few iterations
    start_valid = 1'b1; t_in = '1; cyc = 0;
    step();
    start_valid = 1'b0;
    repeat (11) step();
    check_eq("tmax_busy", 64'(busy), 64'd1);
    check_eq("tmax_rv", 64'(result_valid), 64'd0);
    check_eq("tmax_iter", iter_cnt, 64'd3);
    abort = 1'b1;
    step();
    abort = 1'b0;

    // Asynchronous reset pulse between clock edges mid-RUN
    start_valid = 1'b1; t_in = 64'd10; cyc = 0;
    step();
    start_valid = 1'b0;
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 64'(busy), 64'd0);
    check_eq("arst_stage_en", 64'(stage_en), 64'd0);
    check_eq("arst_start_ready", 64'(start_ready), 64'd1);
    check_eq("arst_iter", iter_cnt, 64'd0);
    #2 rst_n = 1'b1;
    bad_rv = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (result_valid || busy) bad_rv++;
    end
    check_eq("arst_no_rv", 64'(bad_rv), 64'd0);

`ifdef ITER_CHECKPOINT_EN
    begin
      int entries[$];
      int ent_iter[$];
      int ck_wait, frz_bad;
      ck_wait = 0; frz_bad = 0;
      start_valid = 1'b1; t_in = 64'd9; cyc = 0;
      step();
      start_valid = 1'b0;
      while (!result_valid && cyc < 400) begin
        if (ckpt_valid) begin
          if (ck_wait == 0) begin
            entries.push_back(cyc);
            ent_iter.push_back(int'(iter_cnt));
          end
          if (stage_en != '0 || accum_en || load_en) frz_bad++;
          ck_wait++;
          ckpt_ack = (ck_wait == 4);
        end else begin
          ck_wait  = 0;
          ckpt_ack = 1'b0;
        end
        step();
      end
      ckpt_ack = 1'b0;
      check_eq("ck_rv_cyc", 64'(result_valid ? cyc : -1), 64'd37);
      check_eq("ck_entries", 64'(entries.size()), 64'd2);
      check_eq("ck_entry0", 64'(entries.size() > 0 ? entries[0] : -1), 64'd14);
      check_eq("ck_entry1", 64'(entries.size() > 1 ? entries[1] : -1), 64'd30);
      check_eq("ck_iter0", 64'(ent_iter.size() > 0 ? ent_iter[0] : -1), 64'd4);
      check_eq("ck_iter1", 64'(ent_iter.size() > 1 ? ent_iter[1] : -1), 64'd8);
      check_eq("ck_frozen", 64'(frz_bad), 64'd0);
      check_eq("ck_final_iter", iter_cnt, 64'd9);
      result_ready = 1'b1;
      step();
      result_ready = 1'b0;
    end
`else
    check_eq("no_ckpt_valid", 64'(ckpt_valid), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
